cdb_broadcast_unit: RTL and testbench

CDB_BROADCAST_UNIT -- requirements
Module: cdb_broadcast_unit

---
 rtl/cdb_broadcast_unit.sv | 192 +++++++++++++++++++
 tb/tb_cdb_broadcast_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcast_unit.sv
// Purpose: sum/sub and load execution units sharing one registered common data bus (CDB); optional CDB_ROUND_ROBIN_EN sets tie arbitration.
// Latency: issue sampled at edge t -> cdb valid after edge t+LAT for each unit (SUMSUB_LAT / LDSD_LAT), one cycle per broadcast.
// Backpressure: a unit holds in DONE until granted; an issue to a non-idle unit is dropped and flagged in err[0].
module cdb_broadcast_unit #(
    parameter int SUMSUB_LAT = 2,
    parameter int LDSD_LAT   = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] operand1_sumsub,
    input  logic [15:0] operand2_sumsub,
    input  logic [2:0]  Opcode_sumsub,
    input  logic [2:0]  Reg_dest_sumsub,
    input  logic [1:0]  sumsub_position,
    input  logic        operands_ready_sumsub,
    input  logic [15:0] operand1_ldsd,
    input  logic [15:0] operand2_ldsd,
    input  logic [2:0]  Opcode_ldsd,
    input  logic [2:0]  Reg_dest_ldsd,
    input  logic [1:0]  ldsd_position,
    input  logic        operands_ready_ldsd,
    output logic [15:0] cdb,
    output logic        busy_sumsub,
    output logic        busy_ldsd,
    output logic [1:0]  err
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    // With a one-cycle latency the unit skips EXEC and requests the bus on the next edge.
    localparam logic [2:0] SS_CNT_INIT    = 3'(SUMSUB_LAT - 1);
    localparam logic [2:0] LD_CNT_INIT    = 3'(LDSD_LAT - 1);
    localparam state_t     SS_ISSUE_STATE = (SUMSUB_LAT == 1) ? DONE : EXEC;
    localparam state_t     LD_ISSUE_STATE = (LDSD_LAT == 1) ? DONE : EXEC;

    state_t      ss_state, ss_state_nxt, ld_state, ld_state_nxt;
    logic [2:0]  ss_cnt, ss_cnt_nxt, ld_cnt, ld_cnt_nxt;
    logic [15:0] ss_word, ss_word_new, ld_word, ld_word_new;
    logic [9:0]  ss_res, ld_res;
    logic        ss_op_ok, ss_dest_ok, ld_op_ok, ld_dest_ok;
    logic        ss_accept, ld_accept;
    logic        ss_req, ld_req, ss_gnt, ld_gnt;

    // Only the low 10 operand bits take part in the arithmetic.
    logic unused_operand_hi;
    assign unused_operand_hi = ^{operand1_sumsub[15:10], operand2_sumsub[15:10],
                                 operand1_ldsd[15:10], operand2_ldsd[15:10]};

    assign busy_sumsub = (ss_state != IDLE);
    assign busy_ldsd   = (ld_state != IDLE);

    // Sum/sub broadcast word built at capture; a bad destination yields an all-zero word.
    always_comb begin
        ss_op_ok    = (Opcode_sumsub == 3'b000) || (Opcode_sumsub == 3'b001);
        ss_dest_ok  = (Reg_dest_sumsub <= 3'd2);
        ss_res      = 10'd0;
        if (Opcode_sumsub == 3'b000)
            ss_res = operand1_sumsub[9:0] + operand2_sumsub[9:0];
        else if (Opcode_sumsub == 3'b001)
            ss_res = operand1_sumsub[9:0] - operand2_sumsub[9:0];
        ss_word_new = 16'h0000;
        if (ss_dest_ok)
            ss_word_new = {Reg_dest_sumsub == 3'd0, Reg_dest_sumsub == 3'd1,
                           Reg_dest_sumsub == 3'd2, sumsub_position, 1'b1, ss_res};
    end

    // Load broadcast word: effective address, zero result for a non-load opcode.
    always_comb begin
        ld_op_ok    = (Opcode_ldsd == 3'b010);
        ld_dest_ok  = (Reg_dest_ldsd <= 3'd2);
        ld_res      = ld_op_ok ? (operand1_ldsd[9:0] + operand2_ldsd[9:0]) : 10'd0;
        ld_word_new = 16'h0000;
        if (ld_dest_ok)
            ld_word_new = {Reg_dest_ldsd == 3'd0, Reg_dest_ldsd == 3'd1,
                           Reg_dest_ldsd == 3'd2, ldsd_position, 1'b0, ld_res};
    end

`ifdef CDB_ROUND_ROBIN_EN
    logic rr_ld_pri;  // 1: load wins the next tie

    // Pointer moves only on contended grants, away from the unit just granted.
    always_ff @(posedge clock) begin
        if (reset)
            rr_ld_pri <= 1'b0;
        else if (ss_req && ld_req)
            rr_ld_pri <= ss_gnt;
    end
`endif

    // Bus arbitration between the two DONE requests.
    always_comb begin
        ss_req = (ss_state == DONE);
        ld_req = (ld_state == DONE);
`ifdef CDB_ROUND_ROBIN_EN
        ss_gnt = ss_req && (!ld_req || !rr_ld_pri);
        ld_gnt = ld_req && (!ss_req || rr_ld_pri);
`else
        ss_gnt = ss_req;
        ld_gnt = ld_req && !ss_req;
`endif
    end

    // Sum/sub FSM next state: capture in IDLE, count down in EXEC, wait for grant in DONE.
    always_comb begin
        ss_state_nxt = ss_state;
        ss_cnt_nxt   = ss_cnt;
        ss_accept    = 1'b0;
        case (ss_state)
            IDLE: if (operands_ready_sumsub) begin
                ss_accept    = 1'b1;
                ss_state_nxt = SS_ISSUE_STATE;
                ss_cnt_nxt   = SS_CNT_INIT;
            end
            EXEC: if (ss_cnt <= 3'd1) begin
                ss_state_nxt = DONE;
                ss_cnt_nxt   = 3'd0;
            end else begin
                ss_cnt_nxt   = ss_cnt - 3'd1;
            end
            DONE: if (ss_gnt) ss_state_nxt = IDLE;
            default: ss_state_nxt = IDLE;
        endcase
    end

    // Load FSM next state, same shape as sum/sub.
    always_comb begin
        ld_state_nxt = ld_state;
        ld_cnt_nxt   = ld_cnt;
        ld_accept    = 1'b0;
        case (ld_state)
            IDLE: if (operands_ready_ldsd) begin
                ld_accept    = 1'b1;
                ld_state_nxt = LD_ISSUE_STATE;
                ld_cnt_nxt   = LD_CNT_INIT;
            end
            EXEC: if (ld_cnt <= 3'd1) begin
                ld_state_nxt = DONE;
                ld_cnt_nxt   = 3'd0;
            end else begin
                ld_cnt_nxt   = ld_cnt - 3'd1;
            end
            DONE: if (ld_gnt) ld_state_nxt = IDLE;
            default: ld_state_nxt = IDLE;
        endcase
    end

    // State, counters and held results; reset drops any in-flight work.
    always_ff @(posedge clock) begin
        if (reset) begin
            ss_state <= IDLE;
            ld_state <= IDLE;
            ss_cnt   <= 3'd0;
            ld_cnt   <= 3'd0;
            ss_word  <= 16'h0000;
            ld_word  <= 16'h0000;
        end else begin
            ss_state <= ss_state_nxt;
            ld_state <= ld_state_nxt;
            ss_cnt   <= ss_cnt_nxt;
            ld_cnt   <= ld_cnt_nxt;
            if (ss_accept) ss_word <= ss_word_new;
            if (ld_accept) ld_word <= ld_word_new;
        end
    end

    // Registered CDB: the granted word for one cycle, otherwise idle zero.
    always_ff @(posedge clock) begin
        if (reset)
            cdb <= 16'h0000;
        else if (ss_gnt)
            cdb <= ss_word;
        else if (ld_gnt)
            cdb <= ld_word;
        else
            cdb <= 16'h0000;
    end

    // Sticky error flags: busy-unit issue, and bad opcode/destination on accepted issues.
    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 2'b00;
        end else begin
            if ((operands_ready_sumsub && ss_state != IDLE) ||
                (operands_ready_ldsd && ld_state != IDLE))
                err[0] <= 1'b1;
            if ((ss_accept && !(ss_op_ok && ss_dest_ok)) ||
                (ld_accept && !(ld_op_ok && ld_dest_ok)))
                err[1] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_broadcast_unit.sv
// Purpose: self-checking bench for cdb_broadcast_unit against a timeline reference model.
// Latency: model predicts cdb/busy/err per edge; outputs sampled 1 time unit after each rising edge.
// Backpressure: directed collisions, busy-issue and reset cases followed by random issue traffic.
module tb_cdb_broadcast_unit;

    localparam int LAT_SS = 2;
    localparam int LAT_LD = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] operand1_sumsub = '0, operand2_sumsub = '0;
    logic [2:0]  Opcode_sumsub = '0, Reg_dest_sumsub = '0;
    logic [1:0]  sumsub_position = '0;
    logic        operands_ready_sumsub = 1'b0;
    logic [15:0] operand1_ldsd = '0, operand2_ldsd = '0;
    logic [2:0]  Opcode_ldsd = '0, Reg_dest_ldsd = '0;
    logic [1:0]  ldsd_position = '0;
    logic        operands_ready_ldsd = 1'b0;
    logic [15:0] cdb;
    logic        busy_sumsub, busy_ldsd;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    // Reference model: each unit is either free or holding one result that becomes
    // eligible for the bus at a known edge number.
    bit          m_pend [2];
    int          m_ready [2];
    logic [15:0] m_word [2];
    bit          m_ptr_ld;
    logic [1:0]  m_err;
    logic [15:0] m_cdb;
    int          ecount;

    cdb_broadcast_unit #(.SUMSUB_LAT(LAT_SS), .LDSD_LAT(LAT_LD)) dut (
        .clock(clock), .reset(reset),
        .operand1_sumsub(operand1_sumsub), .operand2_sumsub(operand2_sumsub),
        .Opcode_sumsub(Opcode_sumsub), .Reg_dest_sumsub(Reg_dest_sumsub),
        .sumsub_position(sumsub_position), .operands_ready_sumsub(operands_ready_sumsub),
        .operand1_ldsd(operand1_ldsd), .operand2_ldsd(operand2_ldsd),
        .Opcode_ldsd(Opcode_ldsd), .Reg_dest_ldsd(Reg_dest_ldsd),
        .ldsd_position(ldsd_position), .operands_ready_ldsd(operands_ready_ldsd),
        .cdb(cdb), .busy_sumsub(busy_sumsub), .busy_ldsd(busy_ldsd), .err(err)
    );

    always #5 clock = ~clock;

    // Expected broadcast word from the field rules; unit 0 = sum/sub, 1 = load.
    function automatic logic [15:0] exp_word(int unit, logic [15:0] a, logic [15:0] b,
                                             logic [2:0] opc, logic [2:0] dest, logic [1:0] slot);
        int data;
        int w;
        int av = int'(a) % 1024;
        int bv = int'(b) % 1024;
        if (unit == 0)
            data = (opc == 3'd0) ? (av + bv) % 1024 : (opc == 3'd1) ? (av - bv + 1024) % 1024 : 0;
        else
            data = (opc == 3'd2) ? (av + bv) % 1024 : 0;
        if (int'(dest) > 2) return 16'h0000;
        w = (1 << (15 - int'(dest))) + int'(slot) * 2048 + ((unit == 0) ? 1024 : 0) + data;
        return w[15:0];
    endfunction

    function automatic bit is_bad(int unit, logic [2:0] opc, logic [2:0] dest);
        bit op_ok = (unit == 0) ? (opc == 3'd0 || opc == 3'd1) : (opc == 3'd2);
        return !op_ok || int'(dest) > 2;
    endfunction

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit iss [2];
        bit was [2];
        bit req [2];
        int win;
        ecount++;
        if (reset) begin
            m_pend = '{0, 0};
            m_ptr_ld = 0;
            m_err = 2'b00;
            m_cdb = 16'h0000;
            return;
        end
        iss[0] = operands_ready_sumsub;
        iss[1] = operands_ready_ldsd;
        for (int u = 0; u < 2; u++) begin
            was[u] = m_pend[u];
            req[u] = m_pend[u] && (ecount >= m_ready[u]);
            if (iss[u] && was[u]) m_err[0] = 1'b1;
        end
        win = -1;
        if (req[0] && req[1]) begin
`ifdef CDB_ROUND_ROBIN_EN
            win = m_ptr_ld ? 1 : 0;
            m_ptr_ld = (win == 0);
`else
            win = 0;
`endif
        end else if (req[0]) win = 0;
        else if (req[1]) win = 1;
        m_cdb = (win >= 0) ? m_word[win] : 16'h0000;
        if (win >= 0) m_pend[win] = 0;
        if (iss[0] && !was[0]) begin
            m_pend[0] = 1;
            m_ready[0] = ecount + LAT_SS;
            m_word[0] = exp_word(0, operand1_sumsub, operand2_sumsub, Opcode_sumsub,
                                 Reg_dest_sumsub, sumsub_position);
            if (is_bad(0, Opcode_sumsub, Reg_dest_sumsub)) m_err[1] = 1'b1;
        end
        if (iss[1] && !was[1]) begin
            m_pend[1] = 1;
            m_ready[1] = ecount + LAT_LD;
            m_word[1] = exp_word(1, operand1_ldsd, operand2_ldsd, Opcode_ldsd,
                                 Reg_dest_ldsd, ldsd_position);
            if (is_bad(1, Opcode_ldsd, Reg_dest_ldsd)) m_err[1] = 1'b1;
        end
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge, compare every output, then drop the issue strobes.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        chk("cdb", cdb, m_cdb);
        chk("busy_sumsub", {15'b0, busy_sumsub}, {15'b0, m_pend[0]});
        chk("busy_ldsd", {15'b0, busy_ldsd}, {15'b0, m_pend[1]});
        chk("err", {14'b0, err}, {14'b0, m_err});
        operands_ready_sumsub = 1'b0;
        operands_ready_ldsd = 1'b0;
    endtask

    task automatic iss_ss(logic [15:0] a, logic [15:0] b, logic [2:0] opc,
                          logic [2:0] dest, logic [1:0] slot);
        operand1_sumsub = a; operand2_sumsub = b; Opcode_sumsub = opc;
        Reg_dest_sumsub = dest; sumsub_position = slot; operands_ready_sumsub = 1'b1;
    endtask

    task automatic iss_ld(logic [15:0] a, logic [15:0] b, logic [2:0] opc,
                          logic [2:0] dest, logic [1:0] slot);
        operand1_ldsd = a; operand2_ldsd = b; Opcode_ldsd = opc;
        Reg_dest_ldsd = dest; ldsd_position = slot; operands_ready_ldsd = 1'b1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        m_pend = '{0, 0};
        m_ready = '{0, 0};
        m_word = '{16'h0, 16'h0};
        m_ptr_ld = 0;
        m_err = 2'b00;
        m_cdb = 16'h0000;
        ecount = 0;

        // Reset state
        reset = 1'b1;
        ticks(2);
        chk("reset_cdb", cdb, 16'h0000);
        reset = 1'b0;
        tick();

        // Add 5+3 to R1, slot 2
        iss_ss(16'd5, 16'd3, 3'b000, 3'd1, 2'd2);
        ticks(4);

        // Sub 2-3 wraps to 0x3FF
        iss_ss(16'd2, 16'd3, 3'b001, 3'd0, 2'd0);
        ticks(3);
        chk("sub_wrap", cdb, 16'h87FF);
        ticks(1);

        // Load issued one cycle before an add: both finish together
        iss_ld(16'd4, 16'd10, 3'b010, 3'd2, 2'd1);
        tick();
        iss_ss(16'd7, 16'd1, 3'b000, 3'd0, 2'd3);
        ticks(3);
        chk("tie1_first_is_sumsub", {15'b0, cdb[10]}, 16'h0001);
        tick();
        chk("tie1_load_next", cdb, 16'h280E);
        ticks(1);

        // Second collision: arbitration mode decides the winner
        iss_ld(16'd100, 16'd20, 3'b010, 3'd1, 2'd2);
        tick();
        iss_ss(16'd9, 16'd4, 3'b001, 3'd2, 2'd0);
        ticks(5);

        // Issue to a busy unit is dropped; issue right after broadcast accepted
        iss_ss(16'd1, 16'd1, 3'b000, 3'd1, 2'd0);
        tick();
        iss_ss(16'd9, 16'd9, 3'b000, 3'd2, 2'd1);
        tick();
        tick();
        chk("busy_issue_kept_first", cdb, exp_word(0, 16'd1, 16'd1, 3'b000, 3'd1, 2'd0));
        iss_ss(16'd3, 16'd4, 3'b000, 3'd0, 2'd2);
        ticks(3);

        // Bad opcode and bad destination
        reset = 1'b1; tick(); reset = 1'b0;
        iss_ss(16'd5, 16'd5, 3'b011, 3'd0, 2'd0);
        ticks(3);
        iss_ss(16'd5, 16'd5, 3'b000, 3'd3, 2'd1);
        ticks(3);
        iss_ld(16'd1, 16'd1, 3'b000, 3'd1, 2'd0);
        ticks(4);

        // Reset on the edge a broadcast is due, then nothing afterwards
        reset = 1'b1; tick(); reset = 1'b0;
        iss_ss(16'd5, 16'd3, 3'b000, 3'd1, 2'd2);
        iss_ld(16'd2, 16'd2, 3'b010, 3'd0, 2'd3);
        ticks(2);
        reset = 1'b1;
        tick();
        chk("rst_over_bcast", cdb, 16'h0000);
        reset = 1'b0;
        ticks(4);

        // Issue coincident with reset is discarded
        reset = 1'b1;
        iss_ss(16'd8, 16'd8, 3'b000, 3'd0, 2'd0);
        iss_ld(16'd8, 16'd8, 3'b010, 3'd1, 2'd1);
        tick();
        reset = 1'b0;
        ticks(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0)
                iss_ss(16'($urandom), 16'($urandom),
                       ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0)
                iss_ld(16'($urandom), 16'($urandom),
                       ($urandom_range(0, 9) < 8) ? 3'd2 : 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            tick();
        end
        reset = 1'b0;
        ticks(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
